instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
- Instruction-memory side of the fetch interface: answers the datapath's 8-bit fetch address with a 32-bit instruction.
- Memory is 256 x 32 words, filled through a byte-wide valid/ready load port.
- Holds the datapath in reset (cpuHold) until a program is fully loaded, then serves fetches.
- Sits between the board loader (e.g. UART receiver) and Datapath1's fetch stage.

Parameters:
- ADDR_W, 8: fetch address width; depth = 2**ADDR_W words.
- FILL_WORD, 32'hFFFFFFFF: value returned for unloaded addresses and used for padding.

Ports:
- clock  in  1  system clock, rising edge.
- resetGral  in  1  asynchronous, active-high reset.
- loadValid  in  1  loadByte holds a valid program byte.
- loadByte  in  8  program byte, most significant byte of each word first.
- loadLast  in  1  qualifies the final byte of the program.
- loadReady  out  1  block accepts a byte this cycle.
- reloadReq  in  1  single-cycle pulse: discard the program and re-enter LOAD.
- fetchAddr  in  ADDR_W  word address from the datapath fetch stage.
- instruction  out  32  registered instruction for fetchAddr.
- cpuHold  out  1  high while no valid program is present; drives the datapath reset.
- wordCount  out  ADDR_W+1  number of words committed (0..256).

Behaviour:
- States: LOAD, RUN. resetGral forces LOAD.
- Reset values: instruction=FILL_WORD, cpuHold=1, loadReady=0, wordCount=0, byte index=0.
- loadReady is 0 in the first cycle after reset release and 1 afterwards while in LOAD and wordCount<256. It is 0 in RUN.
- A byte is accepted only when loadValid && loadReady.
- The assembler shifts each accepted byte into its low byte (first byte ends up in [31:24]).
- On the 4th byte the word is written to mem[wordCount], wordCount increments, and the byte index returns to 0.
- loadLast on an accepted byte ends the load:
  - A partial word is padded in its low byte lanes with 8'hFF, then committed.
  - The state then goes to RUN on the next edge.
- If wordCount reaches 256 without loadLast, the state goes to RUN automatically and further bytes are not accepted.
- loadLast with zero bytes ever accepted is not possible, since loadLast must ride on a byte. A program is therefore at least 1 word.
- cpuHold = (state != RUN), registered. It falls in the same cycle the state becomes RUN.
- Fetch path, 1-cycle latency: at each edge, instruction <= (state==RUN && fetchAddr < wordCount) ? mem[fetchAddr] : FILL_WORD.
- reloadReq in RUN, on the next edge:
  - state=LOAD, wordCount=0, byte index=0, cpuHold=1, instruction=FILL_WORD.
  - Memory contents are not cleared; the wordCount gate hides them.
- reloadReq in LOAD:
  - wordCount and byte index clear, restarting the load.
  - Any byte accepted in that same cycle is dropped.
- Reset mid-load: same effect as reloadReq, asynchronously. A partially assembled word is lost.
- Memory write and fetch read never conflict, because reads are gated to RUN and writes to LOAD.

Decomposition:
- Package instr_mem_pkg: state enum {LOAD, RUN}, FILL_WORD, ADDR_W, depth constant.
- Sub-module instr_word_assembler:
  - Contains the byte shift register, 2-bit byte index and padding logic.
  - Outputs wordValid and word[31:0].
- The top level holds the FSM, the memory array, wordCount and the fetch register.

Test Plan:
- Load from reset: assert resetGral, then deassert; load 12 bytes 20 40 02 8A 20 41 00 03 00 20 10 04 with loadLast on the final byte. Required: wordCount=3, cpuHold falls after the final byte. Then fetchAddr=0,1,2 -> instruction=0x2040028A, 0x20410003, 0x00201004, each one cycle later. fetchAddr=3 -> 0xFFFFFFFF.
- Partial word: load bytes A0 05 with loadLast. Required: mem[0]=0xA005FFFF, wordCount=1, RUN.
- Backpressure and gaps: toggle loadValid randomly over a 2-word program. Required: bytes are taken only on loadValid&&loadReady, with the same result as a gapless load. In RUN, loadReady=0 and asserting loadValid has no effect.
- Full memory: stream 1024 bytes without loadLast. Required: wordCount=256, automatic RUN, loadReady=0 afterwards. fetchAddr=255 -> the last word.
- Reload: in RUN, pulse reloadReq. Required: cpuHold=1 and instruction=0xFFFFFFFF on the next edge. fetchAddr=0 -> 0xFFFFFFFF until a new program (1 word 0xA8A00000) is loaded, then fetchAddr=0 -> 0xA8A00000.
- Async reset mid-load: assert resetGral after 6 bytes, off-edge. Required: outputs go to reset values immediately. A following 4-byte load commits to address 0.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package instr_mem_pkg;
  localparam int          IMEM_ADDR_W = 8;
  localparam int          IMEM_DEPTH  = 2**IMEM_ADDR_W;
  localparam logic [31:0] IMEM_FILL   = 32'hFFFF_FFFF;

  typedef enum logic {LOAD, RUN} imem_state_e;
endpackage

// File: rtl/instr_word_assembler.sv
// Packs MSB-first program bytes into 32-bit words; a short final word is
// padded with 8'hFF in its unused low byte lanes.
module instr_word_assembler (
  input  logic        clock,
  input  logic        rst,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  data,
  input  logic        last,
  output logic        wordValid,
  output logic [31:0] word
);
  logic [23:0] sh;
  logic [1:0]  idx;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (take) begin
      sh  <= {sh[15:0], data};
      idx <= last ? 2'd0 : idx + 2'd1;
    end
  end

  // The word is formed combinationally so the top can commit it on the
  // same edge that accepts the closing byte.
  always_comb begin
    word = '1;
    unique case (idx)
      2'd0:    word = {data, 24'hFF_FFFF};
      2'd1:    word = {sh[7:0], data, 16'hFFFF};
      2'd2:    word = {sh[15:0], data, 8'hFF};
      default: word = {sh[23:0], data};
    endcase
  end

  assign wordValid = take && (last || idx == 2'd3);
endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory fed by a byte-wide load port; holds the CPU in reset
// until a program is committed, then serves registered fetches.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int          ADDR_W    = IMEM_ADDR_W,
  parameter logic [31:0] FILL_WORD = IMEM_FILL
) (
  input  logic              clock,
  input  logic              resetGral,
  input  logic              loadValid,
  input  logic [7:0]        loadByte,
  input  logic              loadLast,
  output logic              loadReady,
  input  logic              reloadReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic [31:0]       instruction,
  output logic              cpuHold,
  output logic [ADDR_W:0]   wordCount
);
  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);

  imem_state_e state, state_n;
  logic        armed;
  logic        take;
  logic        wordValid;
  logic [31:0] word;
  logic [31:0] mem [DEPTH];

  // armed keeps loadReady low for the first cycle out of reset.
  assign loadReady = armed && (state == LOAD) && (wordCount != FULL);
  assign take      = loadValid && loadReady && !reloadReq;

  instr_word_assembler u_asm (
    .clock     (clock),
    .rst       (resetGral),
    .clr       (reloadReq),
    .take      (take),
    .data      (loadByte),
    .last      (loadLast),
    .wordValid (wordValid),
    .word      (word)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      LOAD: if (wordValid && (loadLast || wordCount == LAST_IDX)) state_n = RUN;
      RUN:  if (reloadReq) state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clock or posedge resetGral) begin
    if (resetGral) state <= LOAD;
    else           state <= state_n;
  end

  always_ff @(posedge clock or posedge resetGral) begin
    if (resetGral) begin
      armed       <= 1'b0;
      cpuHold     <= 1'b1;
      wordCount   <= '0;
      instruction <= FILL_WORD;
    end else begin
      armed   <= 1'b1;
      cpuHold <= (state_n != RUN);
      if (reloadReq)      wordCount <= '0;
      else if (wordValid) wordCount <= wordCount + 1'b1;
      // wordCount gates stale contents left behind by an earlier program.
      if (state == RUN && !reloadReq && ({1'b0, fetchAddr} < wordCount))
        instruction <= mem[fetchAddr];
      else
        instruction <= FILL_WORD;
    end
  end

  always_ff @(posedge clock) begin
    if (wordValid) mem[wordCount[ADDR_W-1:0]] <= word;
  end
endmodule
